// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, buffers fetched words and hands them to decode.
// Optional performance counters are built when FETCHQ_PERF_EN is defined.
module inst_fetch_queue #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic [DATA_W-1:0]        ram_data,
  input  logic                     br_taken,
  input  logic [ADDR_W-1:0]        br_target,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [DATA_W-1:0]        id_instr,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCHQ_PERF_EN
  ,
  output logic [15:0]              perf_flush_cnt,
  output logic [15:0]              perf_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } fill_state_t;

  fill_state_t state, state_next;

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  cnt_q, cnt_next;
  logic [ADDR_W-1:0] pc;
  logic              push, pop;

  assign ram_addr = pc;
  assign count    = cnt_q;
  assign id_valid = (cnt_q != '0);
  assign id_instr = instr_mem[rd_ptr];
  assign id_pc    = pc_mem[rd_ptr];

  // A full queue may still fetch when the head leaves in the same cycle.
  assign pop  = id_valid & id_ready & ~br_taken;
  assign push = ~br_taken & ((state != S_FULL) | pop);

  always_comb begin
    state_next = state;
    cnt_next   = cnt_q;
    if (br_taken) begin
      state_next = S_EMPTY;
      cnt_next   = '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt_next = cnt_q + CNT_ONE;
        2'b01:   cnt_next = cnt_q - CNT_ONE;
        default: cnt_next = cnt_q;
      endcase
      case (state)
        S_EMPTY: begin
          if (push) state_next = S_PARTIAL;
        end
        S_PARTIAL: begin
          if (push && !pop && cnt_q == CNT_LAST)
            state_next = S_FULL;
          else if (pop && !push && cnt_q == CNT_ONE)
            state_next = S_EMPTY;
        end
        S_FULL: begin
          if (pop && !push) state_next = S_PARTIAL;
        end
        default: state_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_EMPTY;
      cnt_q  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      pc     <= RESET_PC;
    end else begin
      state <= state_next;
      cnt_q <= cnt_next;
      if (br_taken) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        pc     <= br_target;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          pc     <= pc + PC_STEP;
        end
      end
    end
  end

  // Entry storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc;
      instr_mem[wr_ptr] <= ram_data;
    end
  end

`ifdef FETCHQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (br_taken && perf_flush_cnt != 16'hFFFF)
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
      if (id_valid && !id_ready && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed phases plus random traffic
// compared against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk;
  logic        reset;
  logic [31:0] ram_addr;
  logic [31:0] ram_data;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  count;
`ifdef FETCHQ_PERF_EN
  logic [15:0] perf_flush_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  entry_t      model_q[$];
  logic [31:0] model_pc;
  logic [15:0] model_flush;
  logic [15:0] model_stall;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a >> 2) ^ 32'hC0DE_0000;
  endfunction

  assign ram_data = word_at(ram_addr);

  inst_fetch_queue #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(32'd4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .br_taken(br_taken),
    .br_target(br_target),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .count(count)
`ifdef FETCHQ_PERF_EN
    ,
    .perf_flush_cnt(perf_flush_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_pc    = RESET_PC;
    model_flush = '0;
    model_stall = '0;
  endtask

  // One clock of queue behaviour, stated in terms of the queue contents.
  task automatic model_step(input logic br, input logic [31:0] tgt, input logic rdy);
    bit do_pop, do_push;
    if (model_q.size() != 0 && !rdy && model_stall != 16'hFFFF) model_stall++;
    if (br) begin
      if (model_flush != 16'hFFFF) model_flush++;
      model_q.delete();
      model_pc = tgt;
    end else begin
      do_pop  = (model_q.size() != 0) && rdy;
      do_push = (model_q.size() < DEPTH) || do_pop;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        model_q.push_back('{pc: model_pc, instr: word_at(model_pc)});
        model_pc = model_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_all(input bit with_perf);
    checkOutput("count", 64'(count), 64'(model_q.size()));
    checkOutput("id_valid", 64'(id_valid), 64'(model_q.size() != 0));
    checkOutput("ram_addr", 64'(ram_addr), 64'(model_pc));
    if (model_q.size() != 0) begin
      checkOutput("id_pc", 64'(id_pc), 64'(model_q[0].pc));
      checkOutput("id_instr", 64'(id_instr), 64'(model_q[0].instr));
    end
`ifdef FETCHQ_PERF_EN
    if (with_perf) begin
      checkOutput("perf_flush", 64'(perf_flush_cnt), 64'(model_flush));
      checkOutput("perf_stall", 64'(perf_stall_cnt), 64'(model_stall));
    end
`endif
  endtask

  task automatic applyStimulus(input logic br, input logic [31:0] tgt, input logic rdy);
    br_taken  = br;
    br_target = tgt;
    id_ready  = rdy;
    @(posedge clk);
    model_step(br, tgt, rdy);
    #1;
    compare_all(1'b1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    br_taken = 1'b0;
    id_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all(1'b1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    br_target = '0;
    do_reset();

    // Streaming from reset, then a flush back to 0 to start the stall scenario from empty.
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h0, 1'b0);
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b1);

    // Flush while three entries are buffered and decode is ready.
    applyStimulus(1'b1, 32'h100, 1'b0);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("three_entries", 64'(count), 64'd3);
    applyStimulus(1'b1, 32'h40, 1'b1);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1);

    // PC wraps at the top of the address space.
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic        br;
      logic        rdy;
      logic [31:0] tgt;
      br  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0;
      applyStimulus(br, tgt, rdy);
    end

    // Asynchronous reset between edges while full.
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("full_before_reset", 64'(count), 64'(DEPTH));
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all(1'b1);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1);

`ifdef FETCHQ_PERF_EN
    do_reset();
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (3) applyStimulus(1'b1, 32'h200, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (5) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("perf_flush_3", 64'(perf_flush_cnt), 64'd3);
    checkOutput("perf_stall_5", 64'(perf_stall_cnt), 64'd5);
    repeat (66000) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("perf_stall_sat", 64'(perf_stall_cnt), 64'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
